// File: rtl/pool_window_sequencer_pkg.sv
// Shared constants and state encoding for the 2x2 pooling window sequencer.
package pool_window_sequencer_pkg;

  localparam int PIX_DW = 16;
  localparam int IMG_W_DEF = 26;
  localparam int IMG_H_DEF = 26;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_TOP  = 2'd1,
    ST_BOT  = 2'd2,
    ST_CLR  = 2'd3
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_window_sequencer_line_buffer.sv
// One-row pixel store: single port, registered read, reset only on read data.
module pool_line_buffer
  import pool_window_sequencer_pkg::*;
#(
  parameter int DW    = PIX_DW,
  parameter int DEPTH = IMG_W_DEF,
  parameter int AW    = cnt_w(IMG_W_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (re_i) begin
      rd_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rd_q;

endmodule

// File: rtl/pool_window_sequencer.sv
// Reorders a raster pixel stream into 2x2 windows for the max-pooling stage.
module pool_window_sequencer
  import pool_window_sequencer_pkg::*;
#(
  parameter int DW    = PIX_DW,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_pix,
  input  logic                         in_sof,
  output logic [DW-1:0]                pix,
  output logic                         i_2,
  output logic                         num_block_change,
  output logic [$clog2(IMG_H/2)-1:0]   blk_row,
  output logic [$clog2(IMG_W/2)-1:0]   blk_col,
  output logic                         frame_done
);

  localparam int CW  = cnt_w(IMG_W);
  localparam int RW  = cnt_w(IMG_H);
  localparam int BRW = $clog2(IMG_H/2);
  localparam int BCW = $clog2(IMG_W/2);
  localparam bit W_ODD = (IMG_W % 2) == 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_PL = CW'(2*(IMG_W/2) - 1);
  localparam logic [RW-1:0] ROW_PL = RW'(2*(IMG_H/2) - 1);

  state_e          st_q;
  state_e          st_d;
  logic [RW-1:0]   row_q;
  logic [RW-1:0]   row_d;
  logic [CW-1:0]   col_q;
  logic [CW-1:0]   col_d;
  logic [DW-1:0]   hold_q;
  logic            sel_hold_q;
  logic            i2_q;
  logic            nbc_q;
  logic            fd_q;
  logic [BRW-1:0]  blk_row_q;
  logic [BCW-1:0]  blk_col_q;
  logic [DW-1:0]   rd_data;
  logic            hs;
  logic            abort;
  logic            last_win;

  assign in_ready = (st_q == ST_FILL) || (st_q == ST_TOP);
  assign hs       = in_valid && in_ready;
  assign abort    = hs && in_sof && ((row_q != '0) || (col_q != '0));
  assign last_win = (row_q == ROW_PL) && (col_q == COL_PL);

  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  // Only odd rows inside the pooled column range pair up with the buffer.
  assign st_d = (row_d[0] && !(W_ODD && col_d == COL_LAST))
              ? ST_TOP : ST_FILL;

  pool_line_buffer #(
    .DW    (DW),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lbuf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (hs && ((st_q == ST_FILL) || abort)),
    .re_i    (hs && (st_q == ST_TOP) && !abort),
    .addr_i  (abort ? '0 : col_q),
    .wdata_i (in_pix),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_FILL;
      row_q      <= '0;
      col_q      <= '0;
      hold_q     <= '0;
      sel_hold_q <= 1'b0;
      i2_q       <= 1'b0;
      nbc_q      <= 1'b0;
      fd_q       <= 1'b0;
      blk_row_q  <= '0;
      blk_col_q  <= '0;
    end else begin
      i2_q  <= 1'b0;
      nbc_q <= 1'b0;
      fd_q  <= 1'b0;
      unique case (st_q)
        ST_FILL, ST_TOP: begin
          if (abort) begin
            // sof pixel becomes (0,0); the pulse flushes pooling state
            row_q <= '0;
            col_q <= CW'(1);
            st_q  <= ST_FILL;
            nbc_q <= 1'b1;
          end else if (hs && st_q == ST_TOP) begin
            i2_q       <= 1'b1;
            sel_hold_q <= 1'b0;
            hold_q     <= in_pix;
            st_q       <= ST_BOT;
          end else if (hs) begin
            row_q <= row_d;
            col_q <= col_d;
            st_q  <= st_d;
          end
        end
        ST_BOT: begin
          i2_q       <= 1'b1;
          sel_hold_q <= 1'b1;
          if (!col_q[0]) begin
            col_q <= col_d;
            st_q  <= ST_TOP;
          end else begin
            st_q <= ST_CLR;
          end
        end
        ST_CLR: begin
          nbc_q     <= 1'b1;
          fd_q      <= last_win;
          blk_row_q <= BRW'(row_q >> 1);
          blk_col_q <= BCW'(col_q >> 1);
          row_q     <= row_d;
          col_q     <= col_d;
          st_q      <= st_d;
        end
      endcase
    end
  end

  assign pix              = sel_hold_q ? hold_q : rd_data;
  assign i_2              = i2_q;
  assign num_block_change = nbc_q;
  assign blk_row          = blk_row_q;
  assign blk_col          = blk_col_q;
  assign frame_done       = fd_q;

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Directed bench: 4x4 and 5x5 instances, cycle table plus window-stream checks.
module tb_pool_window_sequencer;

  logic clk = 1'b0;
  logic rst;

  logic        v4, sof4, rdy4, i2_4, nbc4, fd4;
  logic [15:0] p4, pix4;
  logic        br4, bc4;
  logic        v5, sof5, rdy5, i2_5, nbc5, fd5;
  logic [15:0] p5, pix5;
  logic        br5, bc5;

  int checks = 0;
  int errors = 0;
  int mon_err4 = 0;
  int mon_err5 = 0;
  int fdc4 = 0;
  int fdc5 = 0;
  int ev4[$];
  int ev5[$];

  always #5 clk = ~clk;

  pool_window_sequencer #(.DW(16), .IMG_W(4), .IMG_H(4)) u4 (
    .clk (clk), .rst (rst),
    .in_valid (v4), .in_ready (rdy4), .in_pix (p4), .in_sof (sof4),
    .pix (pix4), .i_2 (i2_4), .num_block_change (nbc4),
    .blk_row (br4), .blk_col (bc4), .frame_done (fd4)
  );

  pool_window_sequencer #(.DW(16), .IMG_W(5), .IMG_H(5)) u5 (
    .clk (clk), .rst (rst),
    .in_valid (v5), .in_ready (rdy5), .in_pix (p5), .in_sof (sof5),
    .pix (pix5), .i_2 (i2_5), .num_block_change (nbc5),
    .blk_row (br5), .blk_col (bc5), .frame_done (fd5)
  );

  // Event log: pixel value, or 1000 + 100*fd + 10*row + col for a window close
  always @(negedge clk) begin
    if (!rst) begin
      if (i2_4 && nbc4) mon_err4++;
      if (fd4 && !nbc4) mon_err4++;
      if (fd4) fdc4++;
      if (i2_4) ev4.push_back(int'(pix4));
      if (nbc4) ev4.push_back(1000 + 100*int'(fd4) + 10*int'(br4) + int'(bc4));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (i2_5 && nbc5) mon_err5++;
      if (fd5 && !nbc5) mon_err5++;
      if (fd5) fdc5++;
      if (i2_5) ev5.push_back(int'(pix5));
      if (nbc5) ev5.push_back(1000 + 100*int'(fd5) + 10*int'(br5) + int'(bc5));
    end
  end

  typedef struct {
    logic        v;
    logic [15:0] px;
    logic        sof;
    logic        rdy;
    logic        i2;
    logic [15:0] pix;
    logic        nbc;
  } vec_t;

  vec_t tbl [10];
  int exp44 [20];
  int exp55 [20];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic pop_chk(input string nm, input bit sel, input int exp);
    int got;
    got = -1;
    if (!sel) begin
      if (ev4.size() > 0) got = ev4.pop_front();
    end else begin
      if (ev5.size() > 0) got = ev5.pop_front();
    end
    chk(nm, got, exp);
  endtask

  task automatic chk_frame(input string nm, input bit sel, input int exp[20]);
    for (int i = 0; i < 20; i++) begin
      pop_chk($sformatf("%s[%0d]", nm, i), sel, exp[i]);
    end
  endtask

  task automatic put(input bit sel, input int px, input bit sof);
    int n;
    n = 0;
    if (!sel) begin
      v4 = 1'b1; p4 = 16'(px); sof4 = sof;
      while (!rdy4 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end else begin
      v5 = 1'b1; p5 = 16'(px); sof5 = sof;
      while (!rdy5 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got %0d cycles, required < 20", n);
    end
    @(negedge clk);
    v4 = 1'b0; sof4 = 1'b0;
    v5 = 1'b0; sof5 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame4(input bit gaps);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        put(1'b0, r*4 + c + 1, (r == 0) && (c == 0));
      end
    end
  endtask

  task automatic frame5();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        put(1'b1, r*5 + c + 1, (r == 0) && (c == 0));
      end
    end
  endtask

  initial begin
    int base;
    tbl[0] = '{1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[1] = '{1'b1, 16'd2, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[2] = '{1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[3] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[4] = '{1'b1, 16'd5, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0};
    tbl[5] = '{1'b1, 16'd6, 1'b0, 1'b0, 1'b1, 16'd5, 1'b0};
    tbl[6] = '{1'b1, 16'd6, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0};
    tbl[7] = '{1'b1, 16'd7, 1'b0, 1'b0, 1'b1, 16'd6, 1'b0};
    tbl[8] = '{1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    tbl[9] = '{1'b1, 16'd7, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0};
    exp44 = '{1, 5, 2, 6, 1000, 3, 7, 4, 8, 1001,
              9, 13, 10, 14, 1010, 11, 15, 12, 16, 1111};
    exp55 = '{1, 6, 2, 7, 1000, 3, 8, 4, 9, 1001,
              11, 16, 12, 17, 1010, 13, 18, 14, 19, 1111};

    rst = 1'b1;
    v4 = 1'b0; p4 = '0; sof4 = 1'b0;
    v5 = 1'b0; p5 = '0; sof5 = 1'b0;
    idle(2);
    chk("rst_pix", int'(pix4), 0);
    chk("rst_i2", int'(i2_4), 0);
    chk("rst_nbc", int'(nbc4), 0);
    chk("rst_blk", int'({br4, bc4}), 0);
    chk("rst_fd", int'(fd4), 0);
    chk("rst5_outs", int'({i2_5, nbc5, fd5, br5, bc5}), 0);
    rst = 1'b0;
    chk("rst_rdy4", int'(rdy4), 1);
    chk("rst_rdy5", int'(rdy5), 1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v4 = tbl[i].v; p4 = tbl[i].px; sof4 = tbl[i].sof;
      chk($sformatf("tbl%0d_rdy", i), int'(rdy4), int'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_i2", i), int'(i2_4), int'(tbl[i].i2));
      chk($sformatf("tbl%0d_nbc", i), int'(nbc4), int'(tbl[i].nbc));
      if (tbl[i].i2) begin
        chk($sformatf("tbl%0d_pix", i), int'(pix4), int'(tbl[i].pix));
      end
    end

    // Asynchronous reset in the middle of a window
    v4 = 1'b0; sof4 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_pix", int'(pix4), 0);
    chk("midrst_i2", int'(i2_4), 0);
    chk("midrst_nbc", int'(nbc4), 0);
    chk("midrst_blk", int'({br4, bc4}), 0);
    chk("midrst_fd", int'(fd4), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rdy", int'(rdy4), 1);
    ev4.delete();

    frame4(1'b0);
    idle(6);
    chk_frame("f44", 1'b0, exp44);

    frame4(1'b1);
    idle(6);
    chk_frame("f44_gaps", 1'b0, exp44);

    // sof at row 1 col 1 aborts the frame; blk coords stay at (1,1)
    put(1'b0, 1, 1'b1);
    put(1'b0, 2, 1'b0);
    put(1'b0, 3, 1'b0);
    put(1'b0, 4, 1'b0);
    put(1'b0, 5, 1'b0);
    frame4(1'b0);
    idle(6);
    pop_chk("abort_top", 1'b0, 1);
    pop_chk("abort_bot", 1'b0, 5);
    pop_chk("abort_nbc", 1'b0, 1011);
    chk_frame("f44_after_abort", 1'b0, exp44);

    base = fdc4;
    frame4(1'b0);
    frame4(1'b0);
    idle(6);
    chk_frame("b2b_first", 1'b0, exp44);
    chk_frame("b2b_second", 1'b0, exp44);
    chk("b2b_fd_count", fdc4 - base, 2);

    frame5();
    idle(6);
    chk_frame("f55", 1'b1, exp55);
    chk("f55_fd_count", fdc5, 1);

    chk("ev4_leftover", ev4.size(), 0);
    chk("ev5_leftover", ev5.size(), 0);
    chk("mon4_pulse_rules", mon_err4, 0);
    chk("mon5_pulse_rules", mon_err5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_window_sequencer.md
Name: pool_window_sequencer

Overview:
- Sits directly upstream of the max-pooling stage.
- Accepts the convolution/ReLU feature map as a raster stream, one row-major pixel per handshake.
- Reorders it into 2x2 pooling windows: drives each window's 4 pixels on pix with i_2=1, then a one-cycle num_block_change pulse.
- Downstream logic samples the pooled maximum at the edge that ends the num_block_change cycle. Block coordinates and frame_done are exported for that capture logic.

Parameters:
- DW, 16, pixel width (matches pooling pix/out_pix).
- IMG_W, 26, input feature-map width in pixels.
- IMG_H, 26, input feature-map height in pixels.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept in_pix this cycle
- in_pix  in  DW  input pixel, unsigned
- in_sof  in  1  qualified by in_valid; marks row 0 col 0 of a frame
- pix  out  DW  pixel to pooling stage
- i_2  out  1  pix valid for max compare
- num_block_change  out  1  window complete; pooling clears at end of this cycle
- blk_row  out  $clog2(IMG_H/2)  row index of window closing on num_block_change
- blk_col  out  $clog2(IMG_W/2)  column index of window closing on num_block_change
- frame_done  out  1  pulse coincident with num_block_change of the last window

Behaviour:
- Reset (async, rst=1): pix=0, i_2=0, num_block_change=0, blk_row=0, blk_col=0, frame_done=0. Row/col counters=0, state=FILL. in_ready=1 after reset.
- All outputs are registered; in_ready is combinational from state.
- Counters: col 0..IMG_W-1, row 0..IMG_H-1, advanced per accepted pixel; at row IMG_H-1, col IMG_W-1 both wrap to 0.
- Pairs: pooled rows are (2k, 2k+1) for k < IMG_H/2; pooled cols are (2j, 2j+1) for j < IMG_W/2.
- Odd trailing data: if IMG_W is odd, column IMG_W-1 is accepted and discarded. If IMG_H is odd, row IMG_H-1 is accepted and discarded.
- FILL state (even row, or discarded row/column): in_ready=1. Each handshake writes line_buf[col]<=in_pix; no output.
- TOP state (odd row, col in pooled range): in_ready=1. On handshake, the next cycle presents pix=line_buf[col], i_2=1. in_pix is captured into a hold register; go to BOT. With no handshake, i_2=0 next cycle.
- BOT state: in_ready=0. Next cycle presents pix=hold, i_2=1.
  - col even: col++, return to TOP.
  - col odd: go to CLR.
- CLR state: in_ready=0.
  - Next cycle: num_block_change=1, i_2=0, blk_row=row>>1, blk_col=col>>1. frame_done=1 if this is the last window of the frame.
  - Then col++ (with row advance/wrap on the last column) and enter TOP, or FILL if the next pixel is even-row or discarded.
- Window output order: top-left, bottom-left, top-right, bottom-right, then one num_block_change cycle.
- Exactly one idle (i_2=0) cycle between windows; num_block_change and i_2 are never both 1.
- num_block_change, frame_done and i_2 are single-cycle pulses.
- in_sof with in_valid while the counters are not at (0,0):
  - Frame aborts; counters reset, partial window discarded.
  - num_block_change=1 in the next cycle to flush the pooling register. blk_row/blk_col are held; frame_done=0.
  - The in_sof pixel is accepted as row 0 col 0 and written to line_buf[0].
  - If in_sof arrives while in_ready=0, it is held off by the handshake like any pixel.
- in_sof at (0,0): no effect.
- Reset mid-window: outputs clear immediately and the partial window is lost. Pooling shares rst, so no stale maximum remains.
- No arithmetic: pixels pass unmodified at DW bits.

Decomposition:
- Shared CNN package: DW, the state encoding (FILL, TOP, BOT, CLR), and clog2-based counter-width constants.
- One sub-module: pool_line_buffer, IMG_W x DW, single port with registered read.
  - Writes occur only in FILL; reads occur only in TOP/BOT, so no read/write conflict.
  - Read address is col, issued in the cycle of the TOP handshake.

Test Plan:
1. Reset: assert rst mid-simulation -> all outputs 0 within the same cycle; in_ready=1 after release.
2. IMG_W=4, IMG_H=4; pixel = r*4+c+1; continuous in_valid:
   - pix/i_2 sequence: 1,5,2,6, nbc(0,0), 3,7,4,8, nbc(0,1), 9,13,10,14, nbc(1,0), 11,15,12,16, nbc(1,1)+frame_done.
   - With pooling attached: out_pix sampled at each nbc = 6,8,14,16.
3. Same frame with random in_valid gaps -> identical pix order and nbc count; i_2 never 1 without a pending pixel.
4. IMG_W=5, IMG_H=5, all 25 pixels accepted -> exactly 4 windows (maxes 7,9,17,19); column 4 and row 4 never appear on pix.
5. in_sof asserted at row 1 col 1 of a 4x4 frame -> num_block_change pulse with frame_done=0; a following full frame yields 6,8,14,16.
6. Back-to-back frames of the 4x4 image -> frame_done exactly twice; second frame output identical to the first.
